// File: rtl/parking_gate_scheduler_pkg.sv
// Shared encodings for the parking gate scheduler.
// Holds FSM state codes, lane codes and the default lot capacity.
package parking_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic LANE_ENTRY = 1'b0;
    localparam logic LANE_EXIT  = 1'b1;

    localparam int DEFAULT_CAPACITY = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_GRANT = GRANT,
        ST_HOLD  = HOLD
    } state_e;

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Lane-request / gate-status bundle of the parking gate scheduler.
// master: lane sensors (drive requests); slave: the scheduler.
interface parking_gate_scheduler_if #(
    parameter int CNT_W = 4
);
    logic             entry_req;
    logic             exit_req;
    logic             entry_grant;
    logic             exit_grant;
    logic             door_trigger;
    logic             reject;
    logic             busy;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;

    modport master (
        output entry_req, exit_req,
        input  entry_grant, exit_grant, door_trigger,
        input  reject, busy, occupancy, full, empty
    );

    modport slave (
        input  entry_req, exit_req,
        output entry_grant, exit_grant, door_trigger,
        output reject, busy, occupancy, full, empty
    );
endinterface

// File: rtl/parking_gate_scheduler_dwell_timer.sv
// Loadable down-counter that times the gate dwell.
// Ports: clk_40MHz, reset, load, load_val, done (count is zero).
module dwell_timer #(
    parameter int TMR_W = 20
) (
    input  logic             clk_40MHz,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_40MHz or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/parking_gate_scheduler.sv
// Arbitrates the shared gate between entry and exit lanes, tracks occupancy.
// Ports: clk_40MHz, reset, gate (slave bundle: requests in, pulses/status out).
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int CAPACITY     = DEFAULT_CAPACITY,
    parameter int CNT_W        = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int TMR_W        = 20
) (
    input  logic                    clk_40MHz,
    input  logic                    reset,
    parking_gate_scheduler_if.slave gate
);

    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             last_q, last_d;
    logic             armed_q, armed_d;
    logic             entry_grant_q, entry_grant_d;
    logic             exit_grant_q, exit_grant_d;
    logic             trig_q, trig_d;
    logic             reject_q, reject_d;
    logic             busy_q, busy_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    logic tmr_load;
    logic tmr_done;
    logic entry_ok;
    logic exit_ok;

    // Eligibility uses the registered status, i.e. the pre-grant count.
    assign entry_ok = gate.entry_req && !full_q;
    assign exit_ok  = gate.exit_req && !empty_q;

    dwell_timer #(
        .TMR_W(TMR_W)
    ) u_dwell_timer (
        .clk_40MHz(clk_40MHz),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (DWELL_LD),
        .done     (tmr_done)
    );

    always_comb begin
        state_d       = state_q;
        occ_d         = occ_q;
        last_d        = last_q;
        armed_d       = armed_q;
        entry_grant_d = 1'b0;
        exit_grant_d  = 1'b0;
        reject_d      = 1'b0;
        tmr_load      = 1'b0;

        // One reject per request: rearm once the entry request is seen low.
        if (!gate.entry_req) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // On a tie the lane not served last wins.
                if (entry_ok && (!exit_ok || last_q == LANE_EXIT)) begin
                    entry_grant_d = 1'b1;
                    occ_d         = occ_q + CNT_W'(1);
                    last_d        = LANE_ENTRY;
                    state_d       = ST_GRANT;
                end else if (exit_ok) begin
                    exit_grant_d = 1'b1;
                    occ_d        = occ_q - CNT_W'(1);
                    last_d       = LANE_EXIT;
                    state_d      = ST_GRANT;
                end
                if (gate.entry_req && full_q && armed_q) begin
                    reject_d = 1'b1;
                    armed_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                tmr_load = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        trig_d  = entry_grant_d | exit_grant_d;
        busy_d  = (state_d != ST_IDLE);
        full_d  = (occ_d == CAP_V);
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk_40MHz or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            occ_q         <= '0;
            last_q        <= LANE_EXIT;
            armed_q       <= 1'b1;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            trig_q        <= 1'b0;
            reject_q      <= 1'b0;
            busy_q        <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            occ_q         <= occ_d;
            last_q        <= last_d;
            armed_q       <= armed_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
            trig_q        <= trig_d;
            reject_q      <= reject_d;
            busy_q        <= busy_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
        end
    end

    assign gate.entry_grant  = entry_grant_q;
    assign gate.exit_grant   = exit_grant_q;
    assign gate.door_trigger = trig_q;
    assign gate.reject       = reject_q;
    assign gate.busy         = busy_q;
    assign gate.occupancy    = occ_q;
    assign gate.full         = full_q;
    assign gate.empty        = empty_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler: two instances,
// CAPACITY=8 (A) and CAPACITY=2 (B), both with DWELL_CYCLES=4.
`timescale 1ns/1ps
module tb_parking_gate_scheduler;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   failures;

    parking_gate_scheduler_if #(.CNT_W(4)) ga ();
    parking_gate_scheduler_if #(.CNT_W(4)) gb ();

    parking_gate_scheduler #(
        .CAPACITY(8), .CNT_W(4), .DWELL_CYCLES(4), .TMR_W(8)
    ) u_a (
        .clk_40MHz(clk),
        .reset    (rst_a),
        .gate     (ga)
    );

    parking_gate_scheduler #(
        .CAPACITY(2), .CNT_W(4), .DWELL_CYCLES(4), .TMR_W(8)
    ) u_b (
        .clk_40MHz(clk),
        .reset    (rst_b),
        .gate     (gb)
    );

    always #12.5 clk = ~clk;

    // Packed view: {entry_grant, exit_grant, door_trigger, reject,
    //               busy, full, empty, occupancy[3:0]}
    function automatic logic [10:0] ex(bit eg, bit xg, bit tr, bit rj,
                                       bit bz, bit fu, bit em,
                                       logic [3:0] oc);
        return {eg, xg, tr, rj, bz, fu, em, oc};
    endfunction

    function automatic logic [10:0] obs_a();
        return {ga.entry_grant, ga.exit_grant, ga.door_trigger, ga.reject,
                ga.busy, ga.full, ga.empty, ga.occupancy};
    endfunction

    function automatic logic [10:0] obs_b();
        return {gb.entry_grant, gb.exit_grant, gb.door_trigger, gb.reject,
                gb.busy, gb.full, gb.empty, gb.occupancy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst_a = 1'b1;
        ga.entry_req = 1'b0;
        ga.exit_req  = 1'b0;
        repeat (2) tick();
        e = ex(0, 0, 0, 0, 0, 0, 1, 4'd0);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", obs_a(), e);
        end
        rst_a = 1'b0;
        tick();
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs_a(), e);
        end
    endtask

    task automatic test_entry_dwell();
        logic [10:0] e;
        ga.entry_req = 1'b1;
        tick();
        e = ex(1, 0, 1, 0, 1, 0, 0, 4'd1);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL first_grant got=%b exp=%b", obs_a(), e);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            e = ex(0, 0, 0, 0, 1, 0, 0, 4'd1);
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL busy_hold[%0d] got=%b exp=%b", i, obs_a(), e);
            end
        end
        tick();
        e = ex(0, 0, 0, 0, 0, 0, 0, 4'd1);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL busy_fall got=%b exp=%b", obs_a(), e);
        end
        tick();
        e = ex(1, 0, 1, 0, 1, 0, 0, 4'd2);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL second_grant got=%b exp=%b", obs_a(), e);
        end
        ga.entry_req = 1'b0;
        repeat (5) tick();
        e = ex(0, 0, 0, 0, 0, 0, 0, 4'd2);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL second_idle got=%b exp=%b", obs_a(), e);
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] e;
        logic [3:0]  oc;
        bit          ent;
        // 2 -> 3 -> 4 by entry, then exit to 3 so exit was served last.
        ga.entry_req = 1'b1;
        tick();
        e = ex(1, 0, 1, 0, 1, 0, 0, 4'd3);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL prep_entry3 got=%b exp=%b", obs_a(), e);
        end
        repeat (5) tick();
        tick();
        e = ex(1, 0, 1, 0, 1, 0, 0, 4'd4);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL prep_entry4 got=%b exp=%b", obs_a(), e);
        end
        ga.entry_req = 1'b0;
        ga.exit_req  = 1'b1;
        repeat (5) tick();
        tick();
        e = ex(0, 1, 1, 0, 1, 0, 0, 4'd3);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL prep_exit3 got=%b exp=%b", obs_a(), e);
        end
        ga.entry_req = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            ent = (i % 2 == 0);
            oc  = ent ? 4'd4 : 4'd3;
            e   = ex(ent, !ent, 1, 0, 1, 0, 0, oc);
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", i, obs_a(), e);
            end
            repeat (5) tick();
            e = ex(0, 0, 0, 0, 0, 0, 0, oc);
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL rr_gap[%0d] got=%b exp=%b", i, obs_a(), e);
            end
        end
        ga.entry_req = 1'b0;
        ga.exit_req  = 1'b0;
        tick();
    endtask

    task automatic test_full_reject();
        logic [10:0] e;
        int          extra;
        rst_b = 1'b1;
        gb.entry_req = 1'b0;
        gb.exit_req  = 1'b0;
        tick();
        rst_b = 1'b0;
        gb.entry_req = 1'b1;
        tick();
        e = ex(1, 0, 1, 0, 1, 0, 0, 4'd1);
        checks++;
        if (obs_b() !== e) begin
            failures++;
            $display("FAIL fill1 got=%b exp=%b", obs_b(), e);
        end
        repeat (5) tick();
        tick();
        e = ex(1, 0, 1, 0, 1, 1, 0, 4'd2);
        checks++;
        if (obs_b() !== e) begin
            failures++;
            $display("FAIL fill2 got=%b exp=%b", obs_b(), e);
        end
        repeat (5) tick();
        e = ex(0, 0, 0, 0, 0, 1, 0, 4'd2);
        checks++;
        if (obs_b() !== e) begin
            failures++;
            $display("FAIL full_idle got=%b exp=%b", obs_b(), e);
        end
        tick();
        e = ex(0, 0, 0, 1, 0, 1, 0, 4'd2);
        checks++;
        if (obs_b() !== e) begin
            failures++;
            $display("FAIL reject1 got=%b exp=%b", obs_b(), e);
        end
        extra = 0;
        repeat (6) begin
            tick();
            if (gb.reject || gb.entry_grant || gb.door_trigger) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL reject_once got=%0d exp=0", extra);
        end
        gb.entry_req = 1'b0;
        tick();
        gb.entry_req = 1'b1;
        tick();
        e = ex(0, 0, 0, 1, 0, 1, 0, 4'd2);
        checks++;
        if (obs_b() !== e) begin
            failures++;
            $display("FAIL reject2 got=%b exp=%b", obs_b(), e);
        end
        // Re-armed reject coincides with a served exit.
        gb.entry_req = 1'b0;
        tick();
        gb.entry_req = 1'b1;
        gb.exit_req  = 1'b1;
        tick();
        e = ex(0, 1, 1, 1, 1, 0, 0, 4'd1);
        checks++;
        if (obs_b() !== e) begin
            failures++;
            $display("FAIL reject_exit got=%b exp=%b", obs_b(), e);
        end
        gb.entry_req = 1'b0;
        gb.exit_req  = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_empty_exit();
        logic [10:0] e;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        ga.exit_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = ex(0, 0, 0, 0, 0, 0, 1, 4'd0);
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL empty_wait[%0d] got=%b exp=%b", i, obs_a(), e);
            end
        end
        ga.entry_req = 1'b1;
        tick();
        e = ex(1, 0, 1, 0, 1, 0, 0, 4'd1);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL empty_entry got=%b exp=%b", obs_a(), e);
        end
        ga.entry_req = 1'b0;
        repeat (5) tick();
        tick();
        e = ex(0, 1, 1, 0, 1, 0, 1, 4'd0);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL empty_exit got=%b exp=%b", obs_a(), e);
        end
        ga.exit_req = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_hold();
        logic [10:0] e;
        ga.entry_req = 1'b1;
        tick();
        e = ex(1, 0, 1, 0, 1, 0, 0, 4'd1);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL pre_reset_grant got=%b exp=%b", obs_a(), e);
        end
        repeat (2) tick();
        rst_a = 1'b1;
        #1;
        e = ex(0, 0, 0, 0, 0, 0, 1, 4'd0);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs_a(), e);
        end
        tick();
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", obs_a(), e);
        end
        rst_a = 1'b0;
        tick();
        e = ex(1, 0, 1, 0, 1, 0, 0, 4'd1);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL post_reset_grant got=%b exp=%b", obs_a(), e);
        end
        ga.entry_req = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_hold_pulse();
        logic [10:0] e;
        int          grants;
        ga.exit_req = 1'b1;
        tick();
        e = ex(0, 1, 1, 0, 1, 0, 1, 4'd0);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL hp_exit got=%b exp=%b", obs_a(), e);
        end
        ga.exit_req = 1'b0;
        tick();
        ga.entry_req = 1'b1;
        tick();
        ga.entry_req = 1'b0;
        grants = 0;
        repeat (8) begin
            tick();
            if (ga.entry_grant || ga.door_trigger) grants++;
        end
        checks++;
        if (grants !== 0) begin
            failures++;
            $display("FAIL hold_pulse_grants got=%0d exp=0", grants);
        end
        e = ex(0, 0, 0, 0, 0, 0, 1, 4'd0);
        checks++;
        if (obs_a() !== e) begin
            failures++;
            $display("FAIL hold_pulse_end got=%b exp=%b", obs_a(), e);
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst_a        = 1'b1;
        rst_b        = 1'b1;
        checks       = 0;
        failures     = 0;
        ga.entry_req = 1'b0;
        ga.exit_req  = 1'b0;
        gb.entry_req = 1'b0;
        gb.exit_req  = 1'b0;
        test_reset();
        test_entry_dwell();
        test_round_robin();
        test_full_reject();
        test_empty_exit();
        test_reset_mid_hold();
        test_hold_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
